// File: rtl/evtstamp_if.sv
// CSR bus bundle for evtstamp: the bench or host drives the master side, the block is the slave.
interface evtstamp_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/evtstamp.sv
// Multi-channel coarse event timestamper: synchronised edge detect, per-channel pending slot,
// fixed-priority arbiter into a FIFO drained through CSRs, level/overflow interrupt.
module evtstamp #(
  parameter logic [3:0] csr_addr        = 4'h2,
  parameter int         nchannels       = 4,
  parameter int         ts_width        = 24,
  parameter int         fifo_depth_log2 = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  evtstamp_if.slave            csr,
  output logic                 irq,
  input  logic [nchannels-1:0] evt_in
);
  localparam int DEPTH = 1 << fifo_depth_log2;
  localparam int LW    = fifo_depth_log2 + 1;
  localparam int PW    = fifo_depth_log2;

  logic [nchannels-1:0] sync0_q, sync0_d, s1_q, s1_d, s2_q, s2_d;
  logic                 en_q, en_d;
  logic [7:0]           thr_q, thr_d;
  logic [nchannels-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [ts_width-1:0]  cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [nchannels-1:0] pend_vld_q, pend_vld_d, pend_edge_q, pend_edge_d;
  logic [nchannels-1:0][ts_width-1:0] pend_ts_q, pend_ts_d;
  logic [DEPTH-1:0][31:0] mem_q, mem_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [31:0]          csr_do_q, csr_do_d;
  logic                 irq_q, irq_d;

  logic                 sel, wr, clear, empty, pop, full_eff, push;
  logic [2:0]           word;
  logic [nchannels-1:0] rise, fall, det, grant;
  logic [31:0]          push_entry, rdata;
  logic                 unused_bits;

  assign unused_bits = ^{csr.csr_a[9:3], csr.csr_di};

  assign sel      = (csr.csr_a[13:10] == csr_addr);
  assign wr       = sel & csr.csr_we;
  assign word     = csr.csr_a[2:0];
  assign clear    = wr && (word == 3'd0) && csr.csr_di[1];
  assign empty    = (level_q == '0);
  assign pop      = wr && (word == 3'd5) && !empty;
  assign full_eff = (level_q == LW'(DEPTH)) && !pop;
  assign rise     = s1_q & ~s2_q & rise_en_q & {nchannels{en_q}};
  assign fall     = ~s1_q & s2_q & fall_en_q & {nchannels{en_q}};
  assign det      = rise | fall;

  // Fixed priority: lowest-numbered valid slot wins when there is room.
  always_comb begin
    grant      = '0;
    push_entry = '0;
    for (int i = nchannels - 1; i >= 0; i--) begin
      if (pend_vld_q[i] && !full_eff) begin
        grant      = '0;
        grant[i]   = 1'b1;
        push_entry = {pend_edge_q[i], 3'(i), 28'(pend_ts_q[i])};
      end
    end
  end
  assign push = |grant;

  always_comb begin
    sync0_d     = evt_in;
    s1_d        = sync0_q;
    s2_d        = s1_q;
    en_d        = en_q;
    thr_d       = thr_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    cnt_d       = en_q ? cnt_q + ts_width'(1) : cnt_q;
    ovf_d       = ovf_q;
    pend_vld_d  = pend_vld_q;
    pend_edge_d = pend_edge_q;
    pend_ts_d   = pend_ts_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q + LW'(push) - LW'(pop);

    if (wr) begin
      case (word)
        3'd0: begin en_d = csr.csr_di[0]; thr_d = csr.csr_di[15:8]; end
        3'd1: rise_en_d = csr.csr_di[nchannels-1:0];
        3'd2: fall_en_d = csr.csr_di[nchannels-1:0];
        3'd3: if (csr.csr_di[16]) ovf_d = 1'b0;
        default: ;
      endcase
    end

    // A drop outranks a same-cycle overflow-clear write so the loss stays visible.
    for (int i = 0; i < nchannels; i++) begin
      if (grant[i]) pend_vld_d[i] = 1'b0;
      if (det[i]) begin
        if (pend_vld_q[i] && !grant[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_vld_d[i]  = 1'b1;
          pend_edge_d[i] = rise[i];
          pend_ts_d[i]   = cnt_q;
        end
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (clear) begin
      cnt_d      = '0;
      ovf_d      = 1'b0;
      pend_vld_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      3'd0: rdata = {16'b0, thr_q, 7'b0, en_q};
      3'd1: rdata = 32'(rise_en_q);
      3'd2: rdata = 32'(fall_en_q);
      3'd3: rdata = {14'b0, empty, ovf_q, 16'(level_q)};
      3'd4: rdata = 32'(cnt_q);
      3'd5: rdata = empty ? 32'b0 : mem_q[rd_ptr_q];
      default: rdata = '0;
    endcase
    csr_do_d = sel ? rdata : 32'b0;
    irq_d    = ovf_q | ((thr_q != 8'd0) && (16'(level_q) >= 16'(thr_q)));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync0_q     <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      en_q        <= 1'b0;
      thr_q       <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= '0;
      pend_edge_q <= '0;
      pend_ts_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      csr_do_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync0_q     <= sync0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      pend_edge_q <= pend_edge_d;
      pend_ts_q   <= pend_ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      csr_do_q    <= csr_do_d;
      irq_q       <= irq_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge sys_clk) mem_q <= mem_d;

  assign csr.csr_do = csr_do_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_evtstamp.sv
// Directed bench for evtstamp (4 channels, 8-bit timestamps, 4-deep FIFO); expected values
// are queued at issue time and checked by an independent monitor.
module tb_evtstamp;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       irq;
  logic [3:0] evt_in;

  evtstamp_if bus ();

  evtstamp #(
    .csr_addr(4'h2), .nchannels(4), .ts_width(8), .fifo_depth_log2(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr(bus), .irq(irq), .evt_in(evt_in)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { string name; logic [31:0] val; bit is_irq; } exp_t;
  exp_t sb[$];
  bit   issue = 1'b0;
  bit   due   = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge sys_clk) due <= issue;

  // Monitor: the registered response of an issued read (or irq probe) is stable by the negedge.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge sys_clk);
      if (due) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_response: got %h with nothing expected", bus.csr_do);
        end else begin
          e   = sb.pop_front();
          act = e.is_irq ? {31'b0, irq} : bus.csr_do;
          n_cmp++;
          if (act !== e.val) begin
            n_err++;
            $display("FAIL %s: got %h want %h", e.name, act, e.val);
          end
        end
      end
    end
  end

  function automatic logic [13:0] pa(input logic [2:0] w);
    return {4'h2, 7'b0, w};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic rd_raw(input logic [13:0] a, input logic [31:0] v, input string nm);
    bus.csr_a  = a;
    bus.csr_we = 1'b0;
    issue      = 1'b1;
    sb.push_back('{nm, v, 1'b0});
    step(1);
    issue = 1'b0;
  endtask

  task automatic rd(input logic [2:0] w, input logic [31:0] v, input string nm);
    rd_raw(pa(w), v, nm);
  endtask

  task automatic wr(input logic [2:0] w, input logic [31:0] d);
    bus.csr_a  = pa(w);
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    step(1);
    bus.csr_we = 1'b0;
  endtask

  task automatic chk_irq(input logic v, input string nm);
    issue = 1'b1;
    sb.push_back('{nm, {31'b0, v}, 1'b1});
    step(1);
    issue = 1'b0;
  endtask

  task automatic pulse1();
    evt_in[1] = 1'b1; step(2);
    evt_in[1] = 1'b0; step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; evt_in = '0;
    bus.csr_a = '0; bus.csr_we = 1'b0; bus.csr_di = '0;
    step(3);
    sys_rst = 1'b0;

    // Reset state
    rd(0, 32'h0, "rst_ctrl");
    rd(1, 32'h0, "rst_rise_en");
    rd(2, 32'h0, "rst_fall_en");
    rd(3, 32'h0002_0000, "rst_status");
    rd(4, 32'h0, "rst_ts_now");
    rd(5, 32'h0, "rst_fifo_data");
    rd(6, 32'h0, "rst_word6");
    rd(7, 32'h0, "rst_word7");
    rd_raw({4'h3, 7'b0, 3'd3}, 32'h0, "other_page");
    chk_irq(1'b0, "rst_irq");

    // Single rising edge: counter 1 when the input changes, detected two cycles later at 3
    wr(0, 32'h1);
    wr(1, 32'h1);
    evt_in[0] = 1'b1;
    step(4);
    rd(5, 32'h8000_0003, "single_rise_entry");
    rd(3, 32'h0000_0001, "single_rise_level");
    wr(5, 32'h0);
    rd(3, 32'h0002_0000, "single_pop_empty");
    evt_in = '0;
    step(4);

    // All four rise together after a clear: ts=2, channels in order
    wr(1, 32'hF);
    wr(2, 32'hF);
    wr(0, 32'h3);
    evt_in = 4'hF;
    step(8);
    rd(3, 32'h0000_0004, "quad_rise_level");
    rd(5, 32'h8000_0002, "quad_rise_ch0");
    wr(5, 32'h0);
    rd(5, 32'h9000_0002, "quad_rise_ch1");
    wr(5, 32'h0);
    rd(5, 32'hA000_0002, "quad_rise_ch2");
    wr(5, 32'h0);
    rd(5, 32'hB000_0002, "quad_rise_ch3");
    wr(5, 32'h0);
    rd(3, 32'h0002_0000, "quad_drained");

    // All four fall together after a clear
    wr(0, 32'h3);
    evt_in = 4'h0;
    step(8);
    rd(3, 32'h0000_0004, "quad_fall_level");
    rd(5, 32'h0000_0002, "quad_fall_ch0");
    wr(5, 32'h0);
    rd(5, 32'h1000_0002, "quad_fall_ch1");
    wr(0, 32'h2);
    rd(3, 32'h0002_0000, "clear_flush");

    // Threshold 3, six edges on channel 1 into a 4-deep FIFO
    wr(1, 32'h2);
    wr(2, 32'h0);
    wr(0, 32'h0301);
    pulse1(); pulse1();
    step(4);
    rd(3, 32'h0000_0002, "thr_level2");
    chk_irq(1'b0, "thr_irq_below");
    pulse1();
    step(4);
    rd(3, 32'h0000_0003, "thr_level3");
    chk_irq(1'b1, "thr_irq_at");
    pulse1(); pulse1(); pulse1();
    step(4);
    rd(3, 32'h0001_0004, "full_overflow");
    chk_irq(1'b1, "ovf_irq");
    wr(3, 32'h0001_0000);
    rd(3, 32'h0000_0004, "ovf_cleared");
    chk_irq(1'b1, "irq_level_still");
    wr(5, 32'h0);
    rd(3, 32'h0000_0004, "pop_with_pending_push");
    wr(5, 32'h0);
    rd(3, 32'h0000_0003, "pop_level3");
    chk_irq(1'b1, "irq_level3");
    wr(5, 32'h0);
    rd(3, 32'h0000_0002, "pop_level2");
    chk_irq(1'b0, "irq_dropped");
    wr(0, 32'h2);

    // Wrap: clear at edge C, input changes after C+254, detected when counter wraps to 0
    wr(1, 32'h1);
    wr(0, 32'h3);
    step(254);
    evt_in[0] = 1'b1;
    step(4);
    rd(5, 32'h8000_0000, "wrap_entry");
    rd(4, 32'h0000_0003, "wrap_ts_now");
    rd(3, 32'h0000_0001, "wrap_no_flag");

    // Clear colliding with a detection while 3 entries are queued
    wr(1, 32'hF);
    evt_in = 4'b0111;
    step(5);
    rd(3, 32'h0000_0003, "pre_clear_level3");
    evt_in = 4'b1111;
    step(2);
    wr(0, 32'h3);
    rd(4, 32'h0000_0000, "clear_ts_zero");
    rd(3, 32'h0002_0000, "clear_empty");
    step(4);
    rd(3, 32'h0002_0000, "clear_edge_dropped");
    chk_irq(1'b0, "clear_irq");

    step(3);
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d outstanding want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
